// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF stage
// and the memory controller; hits answer in one cycle, misses hold a level request.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  IF_in,
    input  logic [ADDR_WIDTH-1:0] IF_addr_in,
    output logic                  IF_instE_out,
    output logic [31:0]           IF_inst_out,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic                  mem_instE_in,
    input  logic [31:0]           mem_inst_in
);

    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e                  state_q, state_d;
    logic                    drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic                    inst_e_q, inst_e_d;
    logic [31:0]             inst_q, inst_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;

    logic [TAG_BITS-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]             data_mem [NUM_LINES];

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic                    unused_addr_bits;

    assign req_idx  = IF_addr_in[INDEX_BITS+1:2];
    assign req_tag  = IF_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx = miss_addr_q[INDEX_BITS+1:2];
    assign fill_tag = miss_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Fetch addresses are always word aligned; the byte offset carries no information.
    assign unused_addr_bits = ^IF_addr_in[1:0];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        drop_d      = drop_q;
        miss_addr_d = miss_addr_q;
        inst_e_d    = inst_e_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        fill_en     = 1'b0;

        if (rdy_in) begin
            inst_e_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (IF_in && !clear_in) begin
                        if (hit) begin
                            inst_e_d = 1'b1;
                            inst_d   = data_mem[req_idx];
                        end else begin
                            miss_addr_d = {IF_addr_in[ADDR_WIDTH-1:2], 2'b00};
                            drop_d      = 1'b0;
                            state_d     = MISS;
                        end
                    end
                end
                MISS: begin
                    if (clear_in) begin
                        drop_d = 1'b1;
                    end
                    // A squashed fill still lands in the array; only the IF response is dropped.
                    if (mem_instE_in) begin
                        fill_en           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        if (!drop_q && !clear_in) begin
                            inst_e_d = 1'b1;
                            inst_d   = mem_inst_in;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            miss_addr_q <= '0;
            inst_e_q    <= 1'b0;
            inst_q      <= '0;
            valid_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            drop_q      <= drop_d;
            miss_addr_q <= miss_addr_d;
            inst_e_q    <= inst_e_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_inst_in;
        end
    end

    assign IF_instE_out = inst_e_q;
    assign IF_inst_out  = inst_q;
    assign mem_req_out  = (state_q == MISS) && !mem_instE_in;
    assign mem_addr_out = (state_q == MISS) ? miss_addr_q : '0;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetch traffic
// scored against an array-based cache model and an address-derived memory image.
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        IF_in;
    logic [31:0] IF_addr_in;
    logic        IF_instE_out;
    logic [31:0] IF_inst_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_instE_in;
    logic [31:0] mem_inst_in;

    int n_pass  = 0;
    int n_total = 0;

    bit          m_valid [128];
    logic [22:0] m_tag   [128];
    logic [31:0] m_data  [128];

    icache #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_in     (clear_in),
        .IF_in        (IF_in),
        .IF_addr_in   (IF_addr_in),
        .IF_instE_out (IF_instE_out),
        .IF_inst_out  (IF_inst_out),
        .mem_req_out  (mem_req_out),
        .mem_addr_out (mem_addr_out),
        .mem_instE_in (mem_instE_in),
        .mem_inst_in  (mem_inst_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (wa == 32'h0) return 32'h0000_0013;
        if (wa == 32'h4) return 32'h0010_0093;
        return (wa * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // One IF transaction; the memory controller is emulated inline for misses.
    task automatic fetch(input logic [31:0] addr, input int lat, input bit do_clear, input int clr_at);
        logic [31:0] wa;
        logic [31:0] word;
        int          idx;
        logic [22:0] tg;
        bit          exp_hit;
        wa      = {addr[31:2], 2'b00};
        word    = mem_word(wa);
        idx     = int'(addr[8:2]);
        tg      = addr[31:9];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        IF_in      = 1'b1;
        IF_addr_in = addr;
        @(negedge clk_in);
        if (exp_hit) begin
            check("hit_pulse", 32'(IF_instE_out), 32'd1);
            check("hit_data", IF_inst_out, m_data[idx]);
            check("hit_no_req", 32'(mem_req_out), 32'd0);
        end else begin
            check("miss_no_pulse", 32'(IF_instE_out), 32'd0);
            check("miss_req", 32'(mem_req_out), 32'd1);
            check("miss_addr", mem_addr_out, wa);
            IF_addr_in = $urandom;
            for (int i = 0; i < lat; i++) begin
                if (do_clear && i == clr_at) begin
                    clear_in = 1'b1;
                    IF_in    = 1'b0;
                end
                if (i == lat - 1) begin
                    mem_instE_in = 1'b1;
                    mem_inst_in  = word;
                    #1;
                    check("req_drop_on_valid", 32'(mem_req_out), 32'd0);
                end
                @(negedge clk_in);
                clear_in     = 1'b0;
                mem_instE_in = 1'b0;
                mem_inst_in  = $urandom;
                if (i < lat - 1) begin
                    check("req_hold", 32'(mem_req_out), 32'd1);
                    check("addr_hold", mem_addr_out, wa);
                    check("wait_no_pulse", 32'(IF_instE_out), 32'd0);
                end
            end
            check("fill_pulse", 32'(IF_instE_out), do_clear ? 32'd0 : 32'd1);
            if (!do_clear) check("fill_data", IF_inst_out, word);
            check("idle_no_req", 32'(mem_req_out), 32'd0);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = word;
        end
    endtask

    task automatic idle_if();
        IF_in = 1'b0;
        @(negedge clk_in);
        check("pulse_ends", 32'(IF_instE_out), 32'd0);
        check("idle_req", 32'(mem_req_out), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        int          lat;
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        clear_in     = 1'b0;
        IF_in        = 1'b0;
        IF_addr_in   = '0;
        mem_instE_in = 1'b0;
        mem_inst_in  = '0;
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        #1;
        check("rst_pulse", 32'(IF_instE_out), 32'd0);
        check("rst_inst", IF_inst_out, 32'd0);
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", mem_addr_out, 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Cold miss, then preload 0x4, then back-to-back hits.
        fetch(32'h0, 2, 1'b0, 0);
        idle_if();
        fetch(32'h4, 3, 1'b0, 0);
        idle_if();
        fetch(32'h0, 1, 1'b0, 0);
        fetch(32'h4, 1, 1'b0, 0);
        idle_if();

        // Conflict on index 0: 0x200 evicts 0x0, which then misses again.
        fetch(32'h200, 2, 1'b0, 0);
        fetch(32'h0, 2, 1'b0, 0);
        idle_if();

        // Clear mid-miss squashes the response but the line is filled.
        fetch(32'h40, 3, 1'b1, 1);
        idle_if();
        fetch(32'h40, 1, 1'b0, 0);
        idle_if();

        // Stall during MISS, during a fill response, and during a hit response.
        a = 32'h80;
        w = mem_word(a);
        IF_in      = 1'b1;
        IF_addr_in = a;
        @(negedge clk_in);
        check("stall_miss_req", 32'(mem_req_out), 32'd1);
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("stall_req_frozen", 32'(mem_req_out), 32'd1);
            check("stall_addr_frozen", mem_addr_out, a);
            check("stall_no_pulse", 32'(IF_instE_out), 32'd0);
        end
        rdy_in       = 1'b1;
        mem_instE_in = 1'b1;
        mem_inst_in  = w;
        @(negedge clk_in);
        mem_instE_in = 1'b0;
        check("stall_fill_pulse", 32'(IF_instE_out), 32'd1);
        check("stall_fill_data", IF_inst_out, w);
        m_valid[32] = 1'b1;
        m_tag[32]   = 23'd0;
        m_data[32]  = w;
        rdy_in = 1'b0;
        IF_in  = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("stall_fill_pulse_frozen", 32'(IF_instE_out), 32'd1);
            check("stall_fill_data_frozen", IF_inst_out, w);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("stall_fill_release", 32'(IF_instE_out), 32'd0);
        IF_in = 1'b1;
        @(negedge clk_in);
        check("stall_hit_pulse", 32'(IF_instE_out), 32'd1);
        check("stall_hit_data", IF_inst_out, w);
        rdy_in = 1'b0;
        IF_in  = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("stall_hit_frozen", 32'(IF_instE_out), 32'd1);
            check("stall_hit_data_frozen", IF_inst_out, w);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("stall_hit_release", 32'(IF_instE_out), 32'd0);

        // Asynchronous reset in the middle of a miss.
        IF_in      = 1'b1;
        IF_addr_in = 32'h1000;
        @(negedge clk_in);
        check("rstmiss_req", 32'(mem_req_out), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("rstmiss_req_drop", 32'(mem_req_out), 32'd0);
        check("rstmiss_addr", mem_addr_out, 32'd0);
        check("rstmiss_pulse", 32'(IF_instE_out), 32'd0);
        check("rstmiss_inst", IF_inst_out, 32'd0);
        IF_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        @(negedge clk_in);
        fetch(32'h0, 2, 1'b0, 0);
        fetch(32'h0, 1, 1'b0, 0);
        idle_if();

        // Random traffic over a small address pool to mix hits, misses and conflicts.
        for (int n = 0; n < 200; n++) begin
            a   = ({30'd0, 2'($urandom_range(0, 3))} << 9) |
                  ({28'd0, 4'($urandom_range(0, 15))} << 2) |
                  {30'd0, 2'($urandom_range(0, 3))};
            lat = $urandom_range(1, 4);
            fetch(a, lat, ($urandom_range(0, 7) == 0), $urandom_range(0, lat - 1));
            if ($urandom_range(0, 2) == 0) idle_if();
        end
        idle_if();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
